control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Multi-cycle control unit that drives the datapath control bundle from the datapath's instr output, which is the datapath's only outbound port. It latches the instruction into an internal IR and decodes RV32I fields, immediate and control signals from it. It sequences each instruction through FETCH/EXEC/MEM/WB, so the datapath writes registers, writes memory and updates the PC only in the permitted cycles. It also provides a data-memory ready handshake with timeout, halt/illegal detection and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 8, max cycles in S_MEM waiting for dmem_ready before bus error (>=1)
CNT_W, 32, width of retired_count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
instr  in  32  instruction word from datapath
dmem_ready  in  1  data memory accepted/completed access this cycle
opcode  out  7  IR[6:0]
rd  out  5  IR[11:7]
funct3  out  3  IR[14:12]
rs1  out  5  IR[19:15]
rs2  out  5  IR[24:20]
funct7  out  7  IR[31:25]
csr  out  20  IR[31:12]
alu_ctrl  out  4  `ALU_* encoding
imm_out  out  32  sign-extended I/S/B/U/J immediate
reg_write  out  1  register file write enable
mem_read  out  1  data memory read
mem_write  out  1  data memory write
alu_src  out  1  1 = imm_out as ALU op2
op1_sel  out  2  `OP1_RS1 / `OP1_PC (AUIPC) / `OP1_ZERO (LUI)
wb_sel  out  2  `WB_ALU / `WB_MEM / `WB_PC4
is_branch, is_jal, is_jalr  out  1 each  PC redirect qualifiers
pc_en  out  1  PC advance enable
halted  out  1  sequencer stopped (ECALL/EBREAK/illegal/bus error)
illegal  out  1  illegal instruction caused the halt
bus_err  out  1  memory timeout caused the halt
retired_count  out  CNT_W  instructions completed

Behaviour:
- Reset (async, immediate): state=S_FETCH; IR=0x00000013 (NOP), so field outputs decode as NOP; all enables, is_* flags, pc_en, halted, illegal and bus_err are 0; retired_count=0; timeout counter=0.
- S_FETCH (1 cycle): IR<=instr; all enables 0; next S_EXEC.
- S_EXEC (1 cycle): decoded outputs are combinational from IR and stay stable until the next S_FETCH. Enables are 0. Next state:
  - load or store: S_MEM
  - ECALL/EBREAK (0x00000073/0x00100073): S_HALT, halted=1
  - unsupported opcode, bad funct3, or R-type funct7 not in {0x00,0x20(SUB/SRA only)}: S_HALT, illegal=1
  - otherwise: S_WB
- S_MEM:
  - mem_read (load) or mem_write (store) held high every cycle.
  - The access completes on the first cycle with dmem_ready=1; next S_WB.
  - The counter increments on each cycle without dmem_ready. When it reaches MEM_TIMEOUT, next S_HALT with bus_err=1; mem_* drop in S_HALT.
  - The counter is cleared on entering S_MEM.
- S_WB (1 cycle):
  - pc_en=1.
  - reg_write=1 iff the instruction writes rd (not store/branch) and rd!=0.
  - is_branch, is_jal and is_jalr are asserted only here, per opcode.
  - retired_count+1, wrapping at 2^CNT_W.
  - Next S_FETCH.
- S_HALT: terminal until reset. All enables 0; halted=1; halt-cause flags are sticky. An ECALL/EBREAK halt increments retired_count once on entry; illegal and bus-error halts do not.
- Decode:
  - alu_src=1 for OP-IMM, LOAD, STORE, JALR, LUI, AUIPC.
  - Loads and stores use `ALU_ADD`.
  - wb_sel is `WB_MEM` for loads and `WB_PC4` for JAL/JALR; `WB_ALU` otherwise.
  - Shift immediates use IR[24:20] zero-extended; IR[30] selects SRA/SRAI.
  - Branches use `ALU_SUB`; funct3 is passed through for the comparison.
- Latency: 3 cycles for non-memory instructions; 3 + waited cycles + 1 for loads and stores, i.e. 4 with dmem_ready=1 immediately.

Test Plan:
- Reset, instr=0x07B00293 (ADDI x5,x0,123): cycles FETCH,EXEC,WB. Only in the WB cycle: reg_write=1, pc_en=1, rd=5, imm_out=123, alu_src=1, wb_sel=`WB_ALU`. Afterwards retired_count=1.
- instr=0x00502823 (SW x5,16(x0)), dmem_ready low 2 cycles then high: mem_write=1 for exactly 3 cycles, imm_out=16. Then WB with reg_write=0, pc_en=1.
- instr=0x01002303 (LW x6,16(x0)), dmem_ready=1 at once: mem_read for 1 cycle. Then WB with reg_write=1, rd=6, wb_sel=`WB_MEM`.
- instr=0x028000EF (JAL x1,40): imm_out=40, wb_sel=`WB_PC4`. is_jal=1 and reg_write=1 only in WB, coincident with pc_en.
- LW with dmem_ready stuck low: after 8 S_MEM cycles, halted=1 and bus_err=1. mem_read=0, reg_write never asserted, retired_count unchanged. Further instr values are ignored.
- instr=0xFFFFFFFF: illegal=1 and halted=1 after EXEC. Assert reset in the middle of a later S_MEM: all outputs return to reset values immediately, and the next fetch proceeds normally.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I control sequencer: latches the datapath instruction into IR, decodes it,
// and paces register, memory and PC updates through FETCH/EXEC/MEM/WB with a bounded memory wait.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define OP1_RS1  2'd0
`define OP1_PC   2'd1
`define OP1_ZERO 2'd2
`define WB_ALU   2'd0
`define WB_MEM   2'd1
`define WB_PC4   2'd2
`endif

module control_sequencer #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             dmem_ready,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [19:0]      csr,
    output logic [3:0]       alu_ctrl,
    output logic [31:0]      imm_out,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic [1:0]       op1_sel,
    output logic [1:0]       wb_sel,
    output logic             is_branch,
    output logic             is_jal,
    output logic             is_jalr,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   ir;
    logic [TW-1:0] wait_cnt;
    logic          set_illegal, set_bus_err;

    logic dec_legal, dec_load, dec_store, dec_writes_rd, dec_system;
    logic dec_branch, dec_jal, dec_jalr;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign csr    = ir[31:12];
    assign halted = (state == S_HALT);

    // Decode is a pure function of IR, so it holds steady from EXEC until the next fetch.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        dec_legal     = 1'b1;
        dec_load      = 1'b0;
        dec_store     = 1'b0;
        dec_writes_rd = 1'b0;
        dec_system    = 1'b0;
        dec_branch    = 1'b0;
        dec_jal       = 1'b0;
        dec_jalr      = 1'b0;
        alu_ctrl      = `ALU_ADD;
        alu_src       = 1'b0;
        op1_sel       = `OP1_RS1;
        wb_sel        = `WB_ALU;
        imm_out       = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_writes_rd = 1'b1;
                alu_src       = 1'b1;
                op1_sel       = (opcode == OPC_LUI) ? `OP1_ZERO : `OP1_PC;
                imm_out       = {ir[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_writes_rd = 1'b1;
                dec_jal       = 1'b1;
                wb_sel        = `WB_PC4;
                imm_out       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec_legal     = (funct3 == 3'b000);
                dec_writes_rd = 1'b1;
                dec_jalr      = 1'b1;
                alu_src       = 1'b1;
                wb_sel        = `WB_PC4;
                imm_out       = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_BRANCH: begin
                dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec_branch = 1'b1;
                alu_ctrl   = `ALU_SUB;
                imm_out    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OPC_LOAD: begin
                dec_legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec_load      = 1'b1;
                dec_writes_rd = 1'b1;
                alu_src       = 1'b1;
                wb_sel        = `WB_MEM;
                imm_out       = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_STORE: begin
                dec_legal = (funct3 <= 3'b010);
                dec_store = 1'b1;
                alu_src   = 1'b1;
                imm_out   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OPC_OPIMM, OPC_OP: begin
                dec_writes_rd = 1'b1;
                alu_src       = (opcode == OPC_OPIMM);
                imm_out       = (opcode == OPC_OPIMM) ? {{20{ir[31]}}, ir[31:20]} : '0;
                case (funct3)
                    3'b000: alu_ctrl = (opcode == OPC_OP && ir[30]) ? `ALU_SUB : `ALU_ADD;
                    3'b001: alu_ctrl = `ALU_SLL;
                    3'b010: alu_ctrl = `ALU_SLT;
                    3'b011: alu_ctrl = `ALU_SLTU;
                    3'b100: alu_ctrl = `ALU_XOR;
                    3'b101: alu_ctrl = ir[30] ? `ALU_SRA : `ALU_SRL;
                    3'b110: alu_ctrl = `ALU_OR;
                    default: alu_ctrl = `ALU_AND;
                endcase
                // Shift-immediates carry a 5-bit shamt; funct7 only qualifies shifts and SUB/SRA.
                if (opcode == OPC_OPIMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
                    imm_out   = {27'b0, ir[24:20]};
                    dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20 && funct3 == 3'b101);
                end else if (opcode == OPC_OP) begin
                    dec_legal = (funct7 == 7'h00) ||
                                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                end
            end
            OPC_SYSTEM: begin
                dec_system = (ir == ECALL) || (ir == EBREAK);
                dec_legal  = dec_system;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_en       = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (!dec_legal) begin
                    state_nxt   = S_HALT;
                    set_illegal = 1'b1;
                end else if (dec_system) begin
                    state_nxt = S_HALT;
                end else if (dec_load || dec_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = dec_load;
                mem_write = dec_store;
                if (dmem_ready) begin
                    state_nxt = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_WB: begin
                pc_en     = 1'b1;
                reg_write = dec_writes_rd && (rd != 5'd0);
                is_branch = dec_branch;
                is_jal    = dec_jal;
                is_jalr   = dec_jalr;
                state_nxt = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_FETCH;
            ir            <= NOP;
            wait_cnt      <= '0;
            illegal       <= 1'b0;
            bus_err       <= 1'b0;
            retired_count <= '0;
        end else begin
            state   <= state_nxt;
            illegal <= illegal | set_illegal;
            bus_err <= bus_err | set_bus_err;
            if (state == S_FETCH) begin
                ir <= instr;
            end
            if (state != S_MEM) begin
                wait_cnt <= '0;
            end else if (!dmem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // ECALL/EBREAK retire on their way into S_HALT; faults never retire.
            if (state == S_WB || (state == S_EXEC && dec_legal && dec_system)) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-instruction expectations are queued at issue time
// and compared when the sequencer reaches write-back or halts.
module tb_control_sequencer;

    localparam logic [3:0] E_ALU_ADD = 4'd0;
    localparam logic [3:0] E_ALU_SUB = 4'd1;
    localparam logic [3:0] E_ALU_SRA = 4'd7;
    localparam logic [1:0] E_OP1_RS1 = 2'd0;
    localparam logic [1:0] E_OP1_PC  = 2'd1;
    localparam logic [1:0] E_OP1_ZERO = 2'd2;
    localparam logic [1:0] E_WB_ALU  = 2'd0;
    localparam logic [1:0] E_WB_MEM  = 2'd1;
    localparam logic [1:0] E_WB_PC4  = 2'd2;

    localparam int H_NONE = 0;
    localparam int H_SYS  = 1;
    localparam int H_ILL  = 2;
    localparam int H_BUS  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        dmem_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [19:0] csr;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm_out;
    logic        reg_write, mem_read, mem_write, alu_src;
    logic [1:0]  op1_sel, wb_sel;
    logic        is_branch, is_jal, is_jalr, pc_en, halted, illegal, bus_err;
    logic [31:0] retired_count;

    control_sequencer #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .dmem_ready(dmem_ready),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .csr(csr), .alu_ctrl(alu_ctrl), .imm_out(imm_out), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .op1_sel(op1_sel),
        .wb_sel(wb_sel), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .pc_en(pc_en), .halted(halted), .illegal(illegal), .bus_err(bus_err),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          halt;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        asrc;
        logic [1:0]  op1;
        logic [1:0]  wb;
        logic        br, jal, jalr;
        int          rd_cyc, wr_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_retired = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(string tag, int halt, logic rw, logic [4:0] rdv, logic [31:0] imm,
                                logic [3:0] alu, logic asrc, logic [1:0] op1, logic [1:0] wb,
                                logic br, logic jal, logic jalr, int rcy, int wcy);
        exp_t e;
        e.tag = tag; e.halt = halt; e.rw = rw; e.rd = rdv; e.imm = imm; e.alu = alu;
        e.asrc = asrc; e.op1 = op1; e.wb = wb; e.br = br; e.jal = jal; e.jalr = jalr;
        e.rd_cyc = rcy; e.wr_cyc = wcy;
        return e;
    endfunction

    // Drive one instruction from FETCH; ready_delay = wait cycles before dmem_ready, -1 = never.
    task automatic issue(input exp_t e, input logic [31:0] word, input int ready_delay);
        exp_t x;
        int   rd_cyc = 0;
        int   wr_cyc = 0;
        int   stray = 0;
        bit   done = 0;
        bit   popped = 0;
        sb.push_back(e);
        instr = word;
        dmem_ready = 1'b0;
        step();
        check({e.tag, ":exec_enables"},
              {24'b0, reg_write, mem_read, mem_write, pc_en, is_branch, is_jal, is_jalr, halted}, 0);
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            if (halted || pc_en) begin
                done = 1;
                popped = (sb.size() != 0);
                check({e.tag, ":sb_nonempty"}, popped, 1);
                if (popped) begin
                    x = sb.pop_front();
                    if (pc_en) begin
                        check({x.tag, ":reg_write"}, reg_write, x.rw);
                        check({x.tag, ":rd"}, rd, x.rd);
                        check({x.tag, ":imm_out"}, imm_out, x.imm);
                        check({x.tag, ":alu_ctrl"}, alu_ctrl, x.alu);
                        check({x.tag, ":alu_src"}, alu_src, x.asrc);
                        check({x.tag, ":op1_sel"}, op1_sel, x.op1);
                        check({x.tag, ":wb_sel"}, wb_sel, x.wb);
                        check({x.tag, ":redirect"}, {is_branch, is_jal, is_jalr}, {x.br, x.jal, x.jalr});
                        check({x.tag, ":wb_mem_idle"}, {mem_read, mem_write}, 0);
                    end else begin
                        check({x.tag, ":halt_enables"}, {reg_write, mem_read, mem_write, pc_en}, 0);
                    end
                    check({x.tag, ":halted"}, halted, x.halt != H_NONE);
                    check({x.tag, ":illegal"}, illegal, x.halt == H_ILL);
                    check({x.tag, ":bus_err"}, bus_err, x.halt == H_BUS);
                    check({x.tag, ":mem_read_cycles"}, rd_cyc, x.rd_cyc);
                    check({x.tag, ":mem_write_cycles"}, wr_cyc, x.wr_cyc);
                    check({x.tag, ":stray_wb_signals"}, stray, 0);
                end
            end else begin
                if (reg_write || is_branch || is_jal || is_jalr) stray++;
                if (mem_read) rd_cyc++;
                if (mem_write) wr_cyc++;
                dmem_ready = (ready_delay >= 0) && (rd_cyc + wr_cyc == ready_delay + 1);
            end
        end
        check({e.tag, ":completed_in_budget"}, done, 1);
        dmem_ready = 1'b0;
        if (e.halt == H_NONE || e.halt == H_SYS) exp_retired++;
        if (!halted) step();
        check({e.tag, ":retired_count"}, retired_count, exp_retired);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_retired = 0;
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        instr = 32'h0;
        dmem_ready = 1'b0;
        step();
        step();
        check("reset:opcode", opcode, 7'h13);
        check("reset:rd_rs1_f3", {rd, rs1, funct3}, 0);
        check("reset:imm_out", imm_out, 0);
        check("reset:enables", {reg_write, mem_read, mem_write, pc_en, is_branch, is_jal, is_jalr}, 0);
        check("reset:status", {halted, illegal, bus_err}, 0);
        check("reset:retired", retired_count, 0);
        reset = 1'b0;

        issue(mk("addi_x5", H_NONE, 1, 5, 123, E_ALU_ADD, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h07B00293, 0);
        issue(mk("sw", H_NONE, 0, 16, 16, E_ALU_ADD, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 3), 32'h00502823, 2);
        issue(mk("lw", H_NONE, 1, 6, 16, E_ALU_ADD, 1, E_OP1_RS1, E_WB_MEM, 0, 0, 0, 1, 0), 32'h01002303, 0);
        issue(mk("jal", H_NONE, 1, 1, 40, E_ALU_ADD, 0, E_OP1_RS1, E_WB_PC4, 0, 1, 0, 0, 0), 32'h028000EF, 0);
        issue(mk("sub", H_NONE, 1, 3, 0, E_ALU_SUB, 0, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h402081B3, 0);
        issue(mk("addi_x0", H_NONE, 0, 0, 1, E_ALU_ADD, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h00100013, 0);
        issue(mk("beq", H_NONE, 0, 8, 8, E_ALU_SUB, 0, E_OP1_RS1, E_WB_ALU, 1, 0, 0, 0, 0), 32'h00208463, 0);
        issue(mk("lui", H_NONE, 1, 7, 32'h12345000, E_ALU_ADD, 1, E_OP1_ZERO, E_WB_ALU, 0, 0, 0, 0, 0), 32'h123453B7, 0);
        issue(mk("srai", H_NONE, 1, 8, 3, E_ALU_SRA, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h4034D413, 0);
        issue(mk("addi_neg", H_NONE, 1, 10, 32'hFFFFFFFF, E_ALU_ADD, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'hFFF00513, 0);
        issue(mk("jalr", H_NONE, 1, 1, 4, E_ALU_ADD, 1, E_OP1_RS1, E_WB_PC4, 0, 0, 1, 0, 0), 32'h004280E7, 0);
        issue(mk("auipc", H_NONE, 1, 2, 32'h1000, E_ALU_ADD, 1, E_OP1_PC, E_WB_ALU, 0, 0, 0, 0, 0), 32'h00001117, 0);
        issue(mk("ecall", H_SYS, 0, 0, 0, E_ALU_ADD, 0, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h00000073, 0);

        apply_reset();
        issue(mk("lw_timeout", H_BUS, 0, 0, 0, E_ALU_ADD, 0, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 8, 0), 32'h01002303, -1);
        instr = 32'h07B00293;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pc_en || reg_write || mem_read || !halted) bad++;
        end
        check("halt_ignores_instr", bad, 0);
        check("halt_retired_frozen", retired_count, exp_retired);

        apply_reset();
        issue(mk("illegal_ffff", H_ILL, 0, 0, 0, E_ALU_ADD, 0, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'hFFFFFFFF, 0);

        apply_reset();
        issue(mk("addi_pre", H_NONE, 1, 5, 123, E_ALU_ADD, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h07B00293, 0);
        instr = 32'h01002303;
        dmem_ready = 1'b0;
        step();
        step();
        step();
        check("mid_mem:mem_read", mem_read, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_mem_reset:opcode", opcode, 7'h13);
        check("mid_mem_reset:enables", {reg_write, mem_read, mem_write, pc_en, halted, illegal, bus_err}, 0);
        check("mid_mem_reset:retired", retired_count, 0);
        step();
        reset = 1'b0;
        exp_retired = 0;
        issue(mk("addi_post", H_NONE, 1, 5, 123, E_ALU_ADD, 1, E_OP1_RS1, E_WB_ALU, 0, 0, 0, 0, 0), 32'h07B00293, 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
